// File: rtl/stage3_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : stage3_mem_arbiter
// Brief    : Shares one generic memory bus between the fetch port (I) and the
//            memory-stage data port (D). The granted request is registered onto
//            the bus and held there until the bus completes it. Fetches that are
//            abandoned mid-flight, and D requests that are withdrawn, are drained
//            so that a stale response never reaches a requester.
// Revision : 1.0 - initial release
// ============================================================================
module stage3_mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32
) (
    input  logic                CLK,
    input  logic                nRST,
    // fetch port
    input  logic                i_ren,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic [DATA_W-1:0]   i_rdata,
    output logic                i_busy,
    // data port
    input  logic                d_ren,
    input  logic                d_wen,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_byte_en,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_busy,
    // generic memory bus
    output logic                b_ren,
    output logic                b_wen,
    output logic [ADDR_W-1:0]   b_addr,
    output logic [DATA_W-1:0]   b_wdata,
    output logic [DATA_W/8-1:0] b_byte_en,
    input  logic [DATA_W-1:0]   b_rdata,
    input  logic                b_busy
);

    localparam int BE_W = DATA_W / 8;
    localparam int SW   = $clog2(STARVE_LIMIT + 1);

    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] I_ACC = 2'd1;
    localparam logic [1:0] D_ACC = 2'd2;
    localparam logic [1:0] DRAIN = 2'd3;

    logic [1:0]    state;
    logic [SW-1:0] starve_cnt;

    logic d_req;
    logic grant_d;
    logic grant_i;
    logic i_abort;
    logic i_done;
    logic d_done;

    assign d_req = d_ren | d_wen;

    // D wins a tie unless it has already been granted STARVE_LIMIT times in a row
    // while I was waiting.
    assign grant_d = (state == IDLE) & d_req & (~i_ren | (starve_cnt < STARVE_MAX));
    assign grant_i = (state == IDLE) & i_ren & ~grant_d;

    // A fetch is abandoned when it is withdrawn or redirected to another address.
    assign i_abort = ~i_ren | (i_addr != b_addr);

    // Completion terms are masked during reset so busy simply mirrors the request.
    assign i_done = nRST & (state == I_ACC) & ~b_busy & (i_addr == b_addr);
    assign d_done = nRST & (state == D_ACC) & ~b_busy;

    assign i_busy  = i_ren & ~i_done;
    assign d_busy  = d_req & ~d_done;
    assign i_rdata = b_rdata;
    assign d_rdata = b_rdata;

    // Arbitration state, bus request registers and starvation counter.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state      <= IDLE;
            starve_cnt <= '0;
            b_ren      <= 1'b0;
            b_wen      <= 1'b0;
            b_addr     <= '0;
            b_wdata    <= '0;
            b_byte_en  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        state     <= D_ACC;
                        b_ren     <= d_ren;
                        b_wen     <= d_wen;
                        b_addr    <= d_addr;
                        b_wdata   <= d_wdata;
                        b_byte_en <= d_byte_en;
                        if (i_ren) begin
                            if (starve_cnt < STARVE_MAX) begin
                                starve_cnt <= starve_cnt + SW'(1);
                            end
                        end else begin
                            starve_cnt <= '0;
                        end
                    end else if (grant_i) begin
                        state      <= I_ACC;
                        b_ren      <= 1'b1;
                        b_wen      <= 1'b0;
                        b_addr     <= i_addr;
                        b_wdata    <= '0;
                        b_byte_en  <= {BE_W{1'b1}};
                        starve_cnt <= '0;
                    end
                end
                I_ACC: begin
                    // Completion takes priority over an abort seen in the same cycle.
                    if (!b_busy) begin
                        b_ren <= 1'b0;
                        state <= IDLE;
                    end else if (i_abort) begin
                        state <= DRAIN;
                    end
                end
                D_ACC: begin
                    if (!b_busy) begin
                        b_ren <= 1'b0;
                        b_wen <= 1'b0;
                        state <= IDLE;
                    end else if (!d_req) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Bus request stays held; the response is dropped on the floor.
                    if (!b_busy) begin
                        b_ren <= 1'b0;
                        b_wen <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stage3_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_stage3_mem_arbiter
// Brief    : Self-checking bench for stage3_mem_arbiter with a wait-state bus
//            model and an ordered scoreboard of expected completions.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stage3_mem_arbiter;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        i_ren = 1'b0;
    logic [31:0] i_addr = '0;
    logic [31:0] i_rdata;
    logic        i_busy;
    logic        d_ren = 1'b0;
    logic        d_wen = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [3:0]  d_byte_en = '0;
    logic [31:0] d_rdata;
    logic        d_busy;
    logic        b_ren;
    logic        b_wen;
    logic [31:0] b_addr;
    logic [31:0] b_wdata;
    logic [3:0]  b_byte_en;
    logic [31:0] b_rdata;
    logic        b_busy;

    int n_checks = 0;
    int n_fail   = 0;
    int waits    = 0;
    int cnt      = 0;

    logic [31:0] wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [3:0]  wr_be   = '0;

    typedef struct {
        bit          is_i;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    always #5 CLK = ~CLK;

    stage3_mem_arbiter #(.STARVE_LIMIT(4), .ADDR_W(32), .DATA_W(32)) dut (
        .CLK(CLK), .nRST(nRST),
        .i_ren(i_ren), .i_addr(i_addr), .i_rdata(i_rdata), .i_busy(i_busy),
        .d_ren(d_ren), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_byte_en(d_byte_en), .d_rdata(d_rdata), .d_busy(d_busy),
        .b_ren(b_ren), .b_wen(b_wen), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_byte_en(b_byte_en), .b_rdata(b_rdata), .b_busy(b_busy)
    );

    // Bus memory contents as a function of address.
    function automatic logic [31:0] pat(input logic [31:0] a);
        if (a == 32'h200) return 32'hDEADBEEF;
        return a ^ 32'hC3A5_0F00;
    endfunction

    assign b_rdata = pat(b_addr);
    assign b_busy  = (b_ren | b_wen) && (cnt < waits);

    // Bus model: each request is busy for 'waits' cycles, then completes.
    always @(posedge CLK) begin
        if (!nRST) begin
            cnt <= 0;
        end else if (b_ren || b_wen) begin
            if (b_busy) begin
                cnt <= cnt + 1;
            end else begin
                cnt <= 0;
                if (b_wen) begin
                    wr_addr <= b_addr;
                    wr_data <= b_wdata;
                    wr_be   <= b_byte_en;
                end
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic sample();
        @(negedge CLK);
    endtask

    task automatic test_reset();
        nRST = 1'b0; i_ren = 1'b1; i_addr = 32'h40; d_wen = 1'b1; d_addr = 32'h44;
        repeat (3) step();
        sample();
        n_checks++; if (b_ren !== 1'b0) begin n_fail++; $display("FAIL reset_b_ren: got %b want 0", b_ren); end
        n_checks++; if (b_wen !== 1'b0) begin n_fail++; $display("FAIL reset_b_wen: got %b want 0", b_wen); end
        n_checks++; if (b_addr !== 32'h0) begin n_fail++; $display("FAIL reset_b_addr: got %h want 0", b_addr); end
        n_checks++; if (b_wdata !== 32'h0 || b_byte_en !== 4'h0) begin n_fail++; $display("FAIL reset_b_data: got %h/%h want 0/0", b_wdata, b_byte_en); end
        n_checks++; if (i_busy !== 1'b1) begin n_fail++; $display("FAIL reset_i_busy: got %b want 1", i_busy); end
        n_checks++; if (d_busy !== 1'b1) begin n_fail++; $display("FAIL reset_d_busy: got %b want 1", d_busy); end
        step();
        i_ren = 1'b0; d_wen = 1'b0; nRST = 1'b1;
        step();
        sample();
        n_checks++; if (i_busy !== 1'b0 || d_busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b/%b want 0/0", i_busy, d_busy); end
    endtask

    task automatic test_single_fetch();
        exp_t e;
        waits = 0;
        step();
        i_ren = 1'b1; i_addr = 32'h200;
        sb.push_back('{1'b1, pat(32'h200)});
        sample();
        n_checks++; if (b_ren !== 1'b0 || i_busy !== 1'b1) begin n_fail++; $display("FAIL fetch_c0: got b_ren=%b i_busy=%b want 0/1", b_ren, i_busy); end
        step();
        sample();
        n_checks++; if (b_ren !== 1'b1 || b_addr !== 32'h200) begin n_fail++; $display("FAIL fetch_c1_bus: got b_ren=%b b_addr=%h want 1/200", b_ren, b_addr); end
        n_checks++; if (b_byte_en !== 4'hF) begin n_fail++; $display("FAIL fetch_be: got %h want f", b_byte_en); end
        n_checks++; if (i_busy !== 1'b0) begin n_fail++; $display("FAIL fetch_c1_busy: got %b want 0", i_busy); end
        e = sb.pop_front();
        n_checks++; if (i_rdata !== e.data) begin n_fail++; $display("FAIL fetch_rdata: got %h want %h", i_rdata, e.data); end
        step();
        i_ren = 1'b0;
        step();
    endtask

    task automatic test_priority();
        exp_t e;
        int d_done = -1;
        int i_done = -1;
        waits = 2;
        step();
        i_ren = 1'b1; i_addr = 32'h400;
        d_wen = 1'b1; d_addr = 32'h8000; d_wdata = 32'h12345678; d_byte_en = 4'hF;
        sb.push_back('{1'b0, 32'h0});
        sb.push_back('{1'b1, pat(32'h400)});
        for (int c = 0; c < 20 && i_done < 0; c++) begin
            sample();
            if (d_wen && !d_busy && d_done < 0) begin
                d_done = c;
                e = sb.pop_front();
                n_checks++; if (e.is_i !== 1'b0) begin n_fail++; $display("FAIL prio_order: D completed but I expected"); end
                n_checks++; if (b_wen !== 1'b1 || b_addr !== 32'h8000 || b_wdata !== 32'h12345678) begin n_fail++; $display("FAIL prio_d_bus: got wen=%b addr=%h wdata=%h want 1/8000/12345678", b_wen, b_addr, b_wdata); end
            end
            if (i_ren && !i_busy) begin
                i_done = c;
                e = sb.pop_front();
                n_checks++; if (e.is_i !== 1'b1) begin n_fail++; $display("FAIL prio_order: I completed but D expected"); end
                n_checks++; if (i_rdata !== e.data || b_addr !== 32'h400) begin n_fail++; $display("FAIL prio_i_data: got %h@%h want %h@400", i_rdata, b_addr, e.data); end
            end
            step();
            if (d_done >= 0) d_wen = 1'b0;
            if (i_done >= 0) i_ren = 1'b0;
        end
        n_checks++; if (d_done !== 3) begin n_fail++; $display("FAIL prio_d_cycle: got %0d want 3", d_done); end
        n_checks++; if (i_done !== 7) begin n_fail++; $display("FAIL prio_i_cycle: got %0d want 7", i_done); end
        n_checks++; if (wr_addr !== 32'h8000 || wr_data !== 32'h12345678 || wr_be !== 4'hF) begin n_fail++; $display("FAIL prio_write: got %h=%h be %h want 8000=12345678 be f", wr_addr, wr_data, wr_be); end
        sb.delete();
        step();
    endtask

    task automatic test_starvation();
        exp_t e;
        waits = 0;
        step();
        d_ren = 1'b1; d_addr = 32'h700;
        i_ren = 1'b1; i_addr = 32'h600;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++) sb.push_back('{1'b0, pat(32'h700)});
            sb.push_back('{1'b1, pat(32'h600)});
        end
        for (int c = 0; c < 60 && sb.size() > 0; c++) begin
            sample();
            if (d_ren && !d_busy) begin
                e = sb.pop_front();
                n_checks++; if (e.is_i !== 1'b0 || d_rdata !== e.data) begin n_fail++; $display("FAIL starve_d: D done at cycle %0d with %h, want is_i=%b data %h", c, d_rdata, e.is_i, e.data); end
            end
            if (i_ren && !i_busy && sb.size() > 0) begin
                e = sb.pop_front();
                n_checks++; if (e.is_i !== 1'b1 || i_rdata !== e.data) begin n_fail++; $display("FAIL starve_i: I done at cycle %0d with %h, want is_i=%b data %h", c, i_rdata, e.is_i, e.data); end
            end
            step();
        end
        n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL starve_timeout: %0d completions outstanding, want 0", sb.size()); end
        sb.delete();
        d_ren = 1'b0; i_ren = 1'b0;
        step();
        step();
    endtask

    task automatic test_redirect();
        exp_t e;
        int done = -1;
        waits = 3;
        step();
        i_ren = 1'b1; i_addr = 32'h100;
        sb.push_back('{1'b1, pat(32'h300)});
        for (int c = 0; c < 30 && done < 0; c++) begin
            sample();
            if (c == 4) begin
                n_checks++; if (i_busy !== 1'b1 || b_ren !== 1'b1 || b_addr !== 32'h100) begin n_fail++; $display("FAIL redir_drain: got i_busy=%b b_ren=%b b_addr=%h want 1/1/100", i_busy, b_ren, b_addr); end
            end
            if (c == 5) begin
                n_checks++; if (b_ren !== 1'b0) begin n_fail++; $display("FAIL redir_turn: got b_ren=%b want 0", b_ren); end
            end
            if (i_ren && !i_busy) begin
                done = c;
                e = sb.pop_front();
                n_checks++; if (i_rdata !== e.data || b_addr !== 32'h300) begin n_fail++; $display("FAIL redir_data: got %h@%h want %h@300", i_rdata, b_addr, e.data); end
            end
            step();
            if (c == 1) i_addr = 32'h300;
            if (done >= 0) i_ren = 1'b0;
        end
        n_checks++; if (done !== 9) begin n_fail++; $display("FAIL redir_cycle: got %0d want 9", done); end
        sb.delete();
        step();
    endtask

    task automatic test_abort_complete();
        exp_t e;
        waits = 2;
        // withdrawn in the completion cycle
        step();
        i_ren = 1'b1; i_addr = 32'h140;
        sb.push_back('{1'b1, pat(32'h140)});
        sample(); step(); sample(); step(); sample(); step();
        i_ren = 1'b0;
        sample();
        e = sb.pop_front();
        n_checks++; if (b_ren !== 1'b1 || b_busy !== 1'b0 || i_rdata !== e.data) begin n_fail++; $display("FAIL abort_deliver: got b_ren=%b b_busy=%b rdata=%h want 1/0/%h", b_ren, b_busy, i_rdata, e.data); end
        step();
        sample();
        n_checks++; if (b_ren !== 1'b0) begin n_fail++; $display("FAIL abort_nodrain: got b_ren=%b want 0", b_ren); end
        // redirected in the completion cycle
        step();
        i_ren = 1'b1; i_addr = 32'h140;
        sample(); step(); sample(); step(); sample(); step();
        i_addr = 32'h180;
        sample();
        step();
        sample();
        n_checks++; if (b_ren !== 1'b0) begin n_fail++; $display("FAIL redir_nodrain: got b_ren=%b want 0", b_ren); end
        step(); sample(); step(); sample(); step(); sample();
        n_checks++; if (i_busy !== 1'b0 || i_rdata !== pat(32'h180) || b_addr !== 32'h180) begin n_fail++; $display("FAIL redir_next: got busy=%b %h@%h want 0 %h@180", i_busy, i_rdata, b_addr, pat(32'h180)); end
        step();
        i_ren = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int done = -1;
        waits = 5;
        step();
        d_ren = 1'b1; d_addr = 32'h900;
        sample();
        step();
        sample();
        n_checks++; if (b_ren !== 1'b1 || b_busy !== 1'b1) begin n_fail++; $display("FAIL rst_mid_grant: got b_ren=%b b_busy=%b want 1/1", b_ren, b_busy); end
        step();
        nRST = 1'b0;
        sample();
        n_checks++; if (d_busy !== 1'b1 || i_busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got d=%b i=%b want 1/0", d_busy, i_busy); end
        step();
        nRST = 1'b1;
        sample();
        n_checks++; if (b_ren !== 1'b0 || b_wen !== 1'b0 || b_addr !== 32'h0) begin n_fail++; $display("FAIL rst_mid_clear: got ren=%b wen=%b addr=%h want 0/0/0", b_ren, b_wen, b_addr); end
        sb.push_back('{1'b0, pat(32'h900)});
        for (int c = 4; c < 30 && done < 0; c++) begin
            step();
            sample();
            if (c == 4) begin
                n_checks++; if (b_ren !== 1'b1 || b_addr !== 32'h900) begin n_fail++; $display("FAIL rst_mid_regrant: got b_ren=%b b_addr=%h want 1/900", b_ren, b_addr); end
            end
            if (d_ren && !d_busy) begin
                done = c;
                e = sb.pop_front();
                n_checks++; if (d_rdata !== e.data) begin n_fail++; $display("FAIL rst_mid_data: got %h want %h", d_rdata, e.data); end
            end
        end
        n_checks++; if (done !== 9) begin n_fail++; $display("FAIL rst_mid_cycle: got %0d want 9", done); end
        sb.delete();
        step();
        d_ren = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_priority();
        test_starvation();
        test_redirect();
        test_abort_complete();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
